// File: rtl/button_cmd_arbiter_pkg.sv
// Shared constants for the button command path: command codes, button indices
// and the state encodings used by the hold and arbiter FSMs.
package button_cmd_arbiter_pkg;

    localparam int NUM_BTN = 4;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_LEFT  = 3'd1;
    localparam logic [2:0] CMD_RIGHT = 3'd2;
    localparam logic [2:0] CMD_DOWN  = 3'd3;
    localparam logic [2:0] CMD_ROT   = 3'd4;

    localparam int BTN_MIDDLE = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;

    typedef enum logic [1:0] {HOLD_RELEASED, HOLD_DELAY, HOLD_REPEAT} hold_state_e;
    typedef enum logic       {ARB_IDLE, ARB_OFFER} arb_state_e;

    function automatic logic [2:0] btn_code(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_ROT;
            2'd1:    return CMD_DOWN;
            2'd2:    return CMD_LEFT;
            default: return CMD_RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/button_cmd_arbiter_btn_repeat.sv
// One button: rising-edge press detect plus hold/auto-repeat FSM clocked by
// the game tick. evt is a registered one-cycle event strobe.
module btn_repeat
    import button_cmd_arbiter_pkg::*;
#(
    parameter bit REPEAT_EN    = 1'b1,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 2,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    input  logic tick,
    output logic evt
);

    localparam logic [CNT_W-1:0] DELAY_M1 = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_M1  = CNT_W'(REPEAT_RATE - 1);

    logic             prev;
    logic             press;
    logic             evt_d;
    hold_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign press = level & ~prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev    <= 1'b0;
            state_q <= HOLD_RELEASED;
            cnt_q   <= '0;
            evt     <= 1'b0;
        end else begin
            prev    <= level;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt     <= evt_d;
        end
    end

    // Release overrides everything, including a tick in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = press;
        if (!level) begin
            state_d = HOLD_RELEASED;
            cnt_d   = '0;
            evt_d   = 1'b0;
        end else begin
            case (state_q)
                HOLD_RELEASED: begin
                    if (press && REPEAT_EN) begin
                        state_d = HOLD_DELAY;
                        cnt_d   = '0;
                    end
                end
                HOLD_DELAY: begin
                    if (tick) begin
                        if (cnt_q == DELAY_M1) begin
                            evt_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = HOLD_REPEAT;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                HOLD_REPEAT: begin
                    if (tick) begin
                        if (cnt_q == RATE_M1) begin
                            evt_d = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HOLD_RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_cmd_arbiter.sv
// Four button event sources feeding pending flags, serialized onto one
// valid/ready command port by a round-robin arbiter.
module button_cmd_arbiter
    import button_cmd_arbiter_pkg::*;
#(
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 2,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left,
    input  logic       right,
    input  logic       middle,
    input  logic       down,
    input  logic       tick,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic       overrun
);

    logic [NUM_BTN-1:0] lvl, evt, clr, pend_q, pend_d;
    logic               ovr_d, found;
    logic [1:0]         pick, grant_q, grant_d, rr_q, rr_d;
    logic [2:0]         code_q, code_d;
    arb_state_e         state_q, state_d;

    assign lvl = {right, left, down, middle};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_repeat #(
            .REPEAT_EN   (g != BTN_MIDDLE),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE),
            .CNT_W       (CNT_W)
        ) u_btn (
            .clk  (clk),
            .rst_n(rst_n),
            .level(lvl[g]),
            .tick (tick),
            .evt  (evt[g])
        );
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (!found && pend_q[rr_q + 2'(i)]) begin
                found = 1'b1;
                pick  = rr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        code_d  = code_q;
        rr_d    = rr_q;
        clr     = '0;
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    clr[pick] = 1'b1;
                    grant_d   = pick;
                    code_d    = btn_code(pick);
                    state_d   = ARB_OFFER;
                end
            end
            ARB_OFFER: begin
                if (cmd_ready) begin
                    rr_d    = grant_q + 2'd1;
                    code_d  = CMD_NONE;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // An event on a flag being consumed this cycle re-arms it and is not an overrun.
    assign pend_d = (pend_q & ~clr) | evt;
    assign ovr_d  = |(evt & pend_q & ~clr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            code_q  <= CMD_NONE;
            rr_q    <= '0;
            pend_q  <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            code_q  <= code_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            overrun <= ovr_d;
        end
    end

    assign cmd_valid = (state_q == ARB_OFFER);
    assign cmd_code  = code_q;

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Directed bench for button_cmd_arbiter: a vector table for press/arbitration
// timing plus hand sequences for backpressure, auto-repeat, overrun and reset.
module tb_button_cmd_arbiter;
    import button_cmd_arbiter_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       left = 1'b0, right = 1'b0, middle = 1'b0, down = 1'b0;
    logic       tick = 1'b0, cmd_ready = 1'b0;
    logic       cmd_valid, overrun;
    logic [2:0] cmd_code;

    int         n_chk = 0, n_fail = 0, ovr_cnt = 0;
    logic [2:0] acc_q[$];

    typedef struct {
        logic [3:0] btn;   // {right, left, down, middle}
        logic       tk;
        logic       rdy;
        logic       ev;
        logic [2:0] ec;
        logic       eo;
    } vec_t;
    vec_t vecs[$];

    button_cmd_arbiter #(.REPEAT_DELAY(8), .REPEAT_RATE(2), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .left     (left),
        .right    (right),
        .middle   (middle),
        .down     (down),
        .tick     (tick),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic set_btn(input logic [3:0] b);
        middle = b[0]; down = b[1]; left = b[2]; right = b[3];
    endtask

    // Logs handshakes completing at this edge, then samples 1 time unit after it.
    task automatic step();
        if (cmd_valid && cmd_ready) acc_q.push_back(cmd_code);
        @(posedge clk);
        #1;
        if (overrun) ovr_cnt++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; set_btn(4'h0); tick = 1'b0; cmd_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        acc_q.delete(); ovr_cnt = 0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!cmd_valid && k < budget) begin step(); k++; end
        chk(name, int'(cmd_valid), 1);
    endtask

    task automatic add(input logic [3:0] b, input logic tk, input logic rdy,
                       input logic ev, input logic [2:0] ec, input logic eo);
        vec_t v;
        v.btn = b; v.tk = tk; v.rdy = rdy; v.ev = ev; v.ec = ec; v.eo = eo;
        vecs.push_back(v);
    endtask

    task automatic chk_codes(input string name, input logic [2:0] exp);
        int bad = 0;
        foreach (acc_q[i]) if (acc_q[i] != exp) bad++;
        chk(name, bad, 0);
    endtask

    initial begin
        // all four pressed together from rr_ptr=0: ROT, DOWN, LEFT, RIGHT
        for (int i = 0; i < 11; i++) begin
            case (i)
                2:       add(4'hF, 0, 1, 1, CMD_ROT,   0);
                4:       add(4'hF, 0, 1, 1, CMD_DOWN,  0);
                6:       add(4'hF, 0, 1, 1, CMD_LEFT,  0);
                8:       add(4'hF, 0, 1, 1, CMD_RIGHT, 0);
                default: add(4'hF, 0, 1, 0, CMD_NONE,  0);
            endcase
        end
        add(4'h0, 0, 1, 0, CMD_NONE, 0);
        add(4'h0, 0, 1, 0, CMD_NONE, 0);
        // single left press held with no tick: exactly one LEFT, 2 cycles later
        add(4'h4, 0, 1, 0, CMD_NONE, 0);
        add(4'h4, 0, 1, 0, CMD_NONE, 0);
        add(4'h4, 0, 1, 1, CMD_LEFT, 0);
        for (int i = 0; i < 17; i++) add(4'h4, 0, 1, 0, CMD_NONE, 0);
        add(4'h0, 0, 1, 0, CMD_NONE, 0);

        step();
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_code", int'(cmd_code), int'(CMD_NONE));
        chk("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            set_btn(vecs[i].btn); tick = vecs[i].tk; cmd_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d_valid", i), int'(cmd_valid), int'(vecs[i].ev));
            chk($sformatf("vec%0d_code", i), int'(cmd_code), int'(vecs[i].ec));
            chk($sformatf("vec%0d_ovr", i), int'(overrun), int'(vecs[i].eo));
        end
        chk("table_cmd_count", acc_q.size(), 5);

        // backpressure: offer holds steady while a second DOWN press is recorded
        do_reset();
        set_btn(4'h2);
        wait_valid("bp_offer", 6);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) set_btn(4'h0);
            if (i == 5) set_btn(4'h2);
            step();
            chk($sformatf("bp_hold%0d_valid", i), int'(cmd_valid), 1);
            chk($sformatf("bp_hold%0d_code", i), int'(cmd_code), int'(CMD_DOWN));
        end
        cmd_ready = 1'b1;
        step();
        chk("bp_accept_valid", int'(cmd_valid), 0);
        step();
        chk("bp_second_valid", int'(cmd_valid), 1);
        chk("bp_second_code", int'(cmd_code), int'(CMD_DOWN));
        for (int i = 0; i < 6; i++) step();
        chk("bp_count", acc_q.size(), 2);
        chk("bp_overrun", ovr_cnt, 0);

        // auto-repeat on right: press, 8th tick, then every 2nd tick; release on a tick
        do_reset();
        cmd_ready = 1'b1;
        for (int cyc = 0; cyc < 110; cyc++) begin
            set_btn(cyc < 79 ? 4'h8 : 4'h0);
            tick = (cyc % 5 == 4);
            step();
            if (cyc == 38)  chk("rep_after7", acc_q.size(), 1);
            if (cyc == 43)  chk("rep_after8", acc_q.size(), 2);
            if (cyc == 48)  chk("rep_after9", acc_q.size(), 2);
            if (cyc == 53)  chk("rep_after10", acc_q.size(), 3);
        end
        chk("rep_total", acc_q.size(), 5);
        chk_codes("rep_codes", CMD_RIGHT);

        // middle held for 20 ticks never repeats
        do_reset();
        cmd_ready = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            set_btn(4'h1);
            tick = (cyc % 5 == 4);
            step();
        end
        set_btn(4'h0); tick = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mid_count", acc_q.size(), 1);
        chk_codes("mid_codes", CMD_ROT);

        // overrun: first press is offered, second pends, third merges
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            set_btn((cyc % 4 < 2) ? 4'h4 : 4'h0);
            step();
        end
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_still_offer", int'(cmd_valid), 1);
        cmd_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("ovr_cmd_count", acc_q.size(), 2);
        chk_codes("ovr_codes", CMD_LEFT);
        chk("ovr_total", ovr_cnt, 1);

        // reset mid-offer drops the offer and any pending flags
        do_reset();
        set_btn(4'h2);
        wait_valid("rmo_offer", 6);
        set_btn(4'h6);
        step(); step();
        rst_n = 1'b0; set_btn(4'h0);
        step();
        chk("rmo_valid", int'(cmd_valid), 0);
        chk("rmo_code", int'(cmd_code), int'(CMD_NONE));
        rst_n = 1'b1; cmd_ready = 1'b1; acc_q.delete();
        for (int i = 0; i < 10; i++) step();
        chk("rmo_no_cmd", acc_q.size(), 0);

        // button held through reset yields exactly one press afterwards
        rst_n = 1'b0; set_btn(4'h1);
        step(); step();
        rst_n = 1'b1; acc_q.delete();
        for (int i = 0; i < 10; i++) step();
        chk("held_rst_count", acc_q.size(), 1);
        chk_codes("held_rst_code", CMD_ROT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
